// File: rtl/qsn_derotate.sv
// Pipelined inverse quasi-cyclic shift network.
// Undoes a forward rotation O[i] = I[(i+s) mod Z]: out lane i = in lane (i - s) mod Z.
// One log-shifter register stage per shift bit, with an elastic valid/ready chain.

// One log-shifter stage: optionally rotates toward higher lane index by 2^Bit mod Lanes.
module qsn_derotate_stage #(
  parameter int Lanes      = 4,
  parameter int LaneWidth  = 1,
  parameter int ShiftWidth = 2,
  parameter int Bit        = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_vld,
  input  logic [Lanes*LaneWidth-1:0]   in_dat,
  input  logic [ShiftWidth-1:0]        in_sh,
  input  logic                         in_err,
  output logic                         in_rdy,
  output logic                         out_vld,
  output logic [Lanes*LaneWidth-1:0]   out_dat,
  output logic [ShiftWidth-1:0]        out_sh,
  output logic                         out_err,
  input  logic                         out_rdy
);
  localparam int Rot = (1 << Bit) % Lanes;

  logic [Lanes*LaneWidth-1:0] rot_dat;

  // lane j takes lane (j - Rot) mod Lanes; fixed wiring per stage
  for (genvar j = 0; j < Lanes; j++) begin : g_lane
    assign rot_dat[j*LaneWidth +: LaneWidth] =
      in_dat[((j - Rot + Lanes) % Lanes)*LaneWidth +: LaneWidth];
  end

  // an empty stage always accepts, so bubbles collapse without waiting on downstream
  assign in_rdy = !out_vld || out_rdy;

  // load a new beat (or a bubble) whenever this stage is allowed to advance
  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld <= 1'b0;
      out_dat <= '0;
      out_sh  <= '0;
      out_err <= 1'b0;
    end else if (in_rdy) begin
      out_vld <= in_vld;
      if (in_vld) begin
        out_dat <= in_sh[Bit] ? rot_dat : in_dat;
        out_sh  <= in_sh;
        out_err <= in_err;
      end
    end
  end
endmodule

module qsn_derotate #(
  parameter int LiftingFactor = 4,
  parameter int ShiftWidth    = 2,
  parameter int LaneWidth     = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [LiftingFactor*LaneWidth-1:0]  in_data,
  input  logic [ShiftWidth-1:0]               in_shift,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [LiftingFactor*LaneWidth-1:0]  out_data,
  output logic                                out_err
);
  localparam int DW = LiftingFactor*LaneWidth;
  localparam logic [ShiftWidth:0] ZLIM = (ShiftWidth+1)'(LiftingFactor);

  // index 0 is the input side, index ShiftWidth is the output side
  logic                  vld_pipe [ShiftWidth:0];
  logic                  rdy_pipe [ShiftWidth:0];
  logic [DW-1:0]         dat_pipe [ShiftWidth:0];
  logic [ShiftWidth-1:0] sh_pipe  [ShiftWidth:0];
  logic                  err_pipe [ShiftWidth:0];
  logic                  in_bad;
  logic                  unused_sh;

  // shifts that cannot occur for this lifting factor are flagged and zero the payload
  assign in_bad      = {1'b0, in_shift} >= ZLIM;
  assign vld_pipe[0] = in_valid;
  assign dat_pipe[0] = in_bad ? '0 : in_data;
  assign sh_pipe[0]  = in_shift;
  assign err_pipe[0] = in_bad;

  assign rdy_pipe[ShiftWidth] = out_ready;
  assign in_ready  = rdy_pipe[0];
  assign out_valid = vld_pipe[ShiftWidth];
  assign out_data  = dat_pipe[ShiftWidth];
  assign out_err   = err_pipe[ShiftWidth];
  assign unused_sh = ^sh_pipe[ShiftWidth];

  for (genvar k = 0; k < ShiftWidth; k++) begin : g_stage
    qsn_derotate_stage #(
      .Lanes(LiftingFactor), .LaneWidth(LaneWidth),
      .ShiftWidth(ShiftWidth), .Bit(k)
    ) u_stage (
      .clk(clk), .rst(rst),
      .in_vld(vld_pipe[k]), .in_dat(dat_pipe[k]), .in_sh(sh_pipe[k]),
      .in_err(err_pipe[k]), .in_rdy(rdy_pipe[k]),
      .out_vld(vld_pipe[k+1]), .out_dat(dat_pipe[k+1]), .out_sh(sh_pipe[k+1]),
      .out_err(err_pipe[k+1]), .out_rdy(rdy_pipe[k+1])
    );
  end
endmodule

// File: tb/tb_qsn_derotate.sv
// Bench for qsn_derotate: a Z=4 instance and a Z=5 instance share clock and reset.
// Expected beats are queued as they are accepted and popped as they leave the DUT.
module tb_qsn_derotate;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic v4, rdy4, ov4, or4, oe4;
  logic [3:0] d4, od4;
  logic [1:0] s4;
  logic v5, rdy5, ov5, or5, oe5;
  logic [4:0] d5, od5;
  logic [2:0] s5;

  qsn_derotate #(.LiftingFactor(4), .ShiftWidth(2), .LaneWidth(1)) dut4 (
    .clk(clk), .rst(rst), .in_valid(v4), .in_ready(rdy4), .in_data(d4), .in_shift(s4),
    .out_valid(ov4), .out_ready(or4), .out_data(od4), .out_err(oe4));

  qsn_derotate #(.LiftingFactor(5), .ShiftWidth(3), .LaneWidth(1)) dut5 (
    .clk(clk), .rst(rst), .in_valid(v5), .in_ready(rdy5), .in_data(d5), .in_shift(s5),
    .out_valid(ov5), .out_ready(or5), .out_data(od5), .out_err(oe5));

  typedef struct { logic [7:0] data; logic err; int cyc; bit lat; } exp_t;
  exp_t q4[$];
  exp_t q5[$];
  int nchk = 0, nfail = 0, cyc = 0, nout4 = 0;
  bit lat_mode = 0;
  bit b6done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference inverse rotation: out[i] = d[(i - s) mod z]
  function automatic logic [7:0] derot(input logic [7:0] d, input int s, input int z);
    logic [7:0] o = '0;
    for (int i = 0; i < z; i++) o[i] = d[(i - s + z) % z];
    return o;
  endfunction

  // forward QSN: out[i] = d[(i + s) mod z]
  function automatic logic [7:0] fwd(input logic [7:0] d, input int s, input int z);
    logic [7:0] o = '0;
    for (int i = 0; i < z; i++) o[i] = d[(i + s) % z];
    return o;
  endfunction

  task automatic align();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send4(input logic [3:0] d, input logic [1:0] s, input logic [7:0] e);
    v4 = 1'b1; d4 = d; s4 = s;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (rdy4) break;
      if (n == 299) check("accept_timeout4", 0, 1);
    end
    q4.push_back('{data: e, err: 1'b0, cyc: cyc, lat: lat_mode});
    @(posedge clk); #1;
    v4 = 1'b0; d4 = 4'($urandom); s4 = 2'($urandom);
  endtask

  task automatic send5(input logic [4:0] d, input logic [2:0] s, input logic [7:0] e, input logic err);
    v5 = 1'b1; d5 = d; s5 = s;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (rdy5) break;
      if (n == 299) check("accept_timeout5", 0, 1);
    end
    q5.push_back('{data: e, err: err, cyc: cyc, lat: lat_mode});
    @(posedge clk); #1;
    v5 = 1'b0; d5 = 5'($urandom); s5 = 3'($urandom);
  endtask

  task automatic wait_empty();
    for (int n = 0; n < 300; n++) begin
      if (q4.size() == 0 && q5.size() == 0) break;
      @(posedge clk);
    end
    #1;
    check("drain4", q4.size(), 0);
    check("drain5", q5.size(), 0);
  endtask

  // Z=4 output monitor: scoreboard pop, latency and stall-hold checks
  logic ph4; logic [3:0] pd4; logic pe4;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q4.delete(); ph4 = 1'b0;
    end else begin
      if (ph4) begin
        check("hold_valid4", ov4, 1);
        check("hold_data4", od4, pd4);
        check("hold_err4", oe4, pe4);
      end
      if (ov4 && or4) begin
        if (q4.size() == 0) check("unexpected_beat4", 1, 0);
        else begin
          e = q4.pop_front();
          check("data4", {4'b0, od4}, e.data);
          check("err4", oe4, e.err);
          if (e.lat) check("latency4", cyc - e.cyc, 2);
          nout4++;
        end
      end
      ph4 = ov4 && !or4; pd4 = od4; pe4 = oe4;
    end
  end

  // Z=5 output monitor
  logic ph5; logic [4:0] pd5; logic pe5;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q5.delete(); ph5 = 1'b0;
    end else begin
      if (ph5) begin
        check("hold_data5", od5, pd5);
        check("hold_err5", oe5, pe5);
      end
      if (ov5 && or5) begin
        if (q5.size() == 0) check("unexpected_beat5", 1, 0);
        else begin
          e = q5.pop_front();
          check("data5", {3'b0, od5}, e.data);
          check("err5", oe5, e.err);
          if (e.lat) check("latency5", cyc - e.cyc, 3);
        end
      end
      ph5 = ov5 && !or5; pd5 = od5; pe5 = oe5;
    end
  end

  initial begin
    logic [7:0] a8, f8;
    logic [3:0] bp [4];
    int base;
    rst = 1'b1; v4 = 0; v5 = 0; d4 = 0; d5 = 0; s4 = 0; s5 = 0; or4 = 1; or5 = 1;
    idle(2);
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid4", ov4, 0);
    check("rst_out_data4", od4, 0);
    check("rst_out_err4", oe4, 0);
    check("rst_in_ready4", rdy4, 1);
    check("rst_out_valid5", ov5, 0);
    check("rst_in_ready5", rdy5, 1);
    align();

    // single beats, out_ready high
    lat_mode = 1;
    send4(4'b0001, 2'd1, 8'b0010);
    send4(4'b0001, 2'd3, 8'b1000);
    send4(4'b0110, 2'd0, 8'b0110);
    idle(4);

    // round trip through the forward model, back-to-back
    for (int s = 0; s < 4; s++)
      for (int d = 0; d < 16; d++) begin
        a8 = 8'(d);
        f8 = fwd(a8, s, 4);
        send4(f8[3:0], 2'(s), a8);
      end
    idle(4);

    // backpressure: A..D with shift 2, out_ready low while the pipe fills
    lat_mode = 0;
    bp[0] = 4'h1; bp[1] = 4'h3; bp[2] = 4'h7; bp[3] = 4'hA;
    or4 = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) send4(bp[i], 2'd2, derot({4'b0, bp[i]}, 2, 4));
      end
      begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("bp_in_ready_low", rdy4, 0);
        check("bp_out_valid", ov4, 1);
        a8 = derot({4'b0, bp[0]}, 2, 4);
        check("bp_hold_a", od4, a8[3:0]);
        repeat (3) @(posedge clk);
        #1 or4 = 1'b1;
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          check("bp_consecutive", ov4, 1);
        end
      end
    join
    align();
    idle(3);

    // out-of-range and edge shifts on Z=5
    lat_mode = 1;
    send5(5'b10101, 3'd6, 8'h00, 1'b1);
    send5(5'b00001, 3'd2, 8'b00100, 1'b0);
    send5(5'b00001, 3'd4, 8'b10000, 1'b0);
    send5(5'b11011, 3'd5, 8'h00, 1'b1);
    send5(5'b10110, 3'd0, 8'b10110, 1'b0);
    idle(5);

    // reset with two beats stalled in flight
    lat_mode = 0;
    or4 = 1'b0;
    send4(4'b0001, 2'd1, 8'b0010);
    send4(4'b0010, 2'd1, 8'b0100);
    rst = 1'b1;
    align();
    rst = 1'b0;
    @(negedge clk);
    check("mrst_out_valid", ov4, 0);
    check("mrst_in_ready", rdy4, 1);
    check("mrst_out_data", od4, 0);
    check("mrst_out_err", oe4, 0);
    align();
    or4 = 1'b1;
    lat_mode = 1;
    send4(4'b0100, 2'd1, 8'b1000);
    idle(4);

    // bubbles with random backpressure
    lat_mode = 0;
    base = nout4;
    fork
      begin
        logic [3:0] rd;
        logic [1:0] rs;
        for (int i = 0; i < 24; i++) begin
          rd = 4'($urandom);
          rs = 2'($urandom_range(0, 3));
          send4(rd, rs, derot({4'b0, rd}, int'(rs), 4));
          idle(1);
        end
        b6done = 1;
      end
      begin
        for (int n = 0; n < 2000 && !b6done; n++) begin
          @(posedge clk); #1;
          or4 = 1'($urandom_range(0, 1));
        end
        or4 = 1'b1;
      end
    join
    wait_empty();
    check("bubble_count", nout4 - base, 24);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
